// File: rtl/sram_serial_io_ctrl.sv
// ---------------------------------------------------------------------------
// sram_serial_io_ctrl
//
// Bridges a bit-serial host link to a single-port 1024x8 SRAM macro.
//
// The host shifts an {address,data} word into reg_bits over SI, LSB first.
// It then commands a single-byte SRAM write or read. Read data is captured
// into the low byte of reg_bits. From there the host can see it on PO, or
// shift it back out over SO.
//
// Ports
//   CLK     in   1   clock, rising edge
//   RST_N   in   1   asynchronous active-low reset
//   BGN     in   1   operation enable; low aborts or holds IDLE
//   SI      in   1   serial data in, LSB first
//   LOAD_N  in   1   active-low start strobe, qualified by BGN
//   CTRL    in   2   00 load-shift, 01 SRAM read, 11 SRAM write, 10 shift-out
//   PI      in   8   SRAM Q
//   RDY     out  1   operation complete, level until BGN drops
//   D_WE    out  1   SRAM WEN, active low (1 = read)
//   CEN     out  1   SRAM chip enable, active low
//   SO      out  1   serial out, reg_bits[0]
//   A       out  10  SRAM address, upper field of reg_bits
//   PO      out  8   SRAM D, lower field of reg_bits
//
// Configuration macro
//   SRAM_IO_CTRL_SHIFTOUT_EN
//     Defined:   CTRL=10 rotates reg_bits once per cycle for a full word,
//                streaming it out on SO and leaving it unchanged at the end.
//     Undefined: CTRL=10 is a no-op that completes immediately.
// ---------------------------------------------------------------------------
module sram_serial_io_ctrl #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10,
  parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         BGN,
  input  logic                         SI,
  input  logic                         LOAD_N,
  input  logic [1:0]                   CTRL,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         RDY,
  output logic                         D_WE,
  output logic                         CEN,
  output logic                         SO,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO
);

  localparam int CNT_W = $clog2(REG_BITS_WIDTH);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(REG_BITS_WIDTH - 1);

  localparam logic [1:0] CTRL_LOAD  = 2'b00;
  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_SHOUT = 2'b10;
  localparam logic [1:0] CTRL_WRITE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    SRAM_ACC,
    SRAM_CAP,
    DONE
  } state_t;

  state_t                    state, state_next;
  logic [REG_BITS_WIDTH-1:0] reg_bits, reg_next;
  logic [CNT_W-1:0]          shift_cnt, cnt_next;
  logic [1:0]                ctrl_q, ctrl_next;
  logic                      rdy_q, cen_q, d_we_q;

  // The SRAM-facing fields and the serial output come straight from the
  // shift register, so they are valid in every state, not only at DONE.
  assign A    = reg_bits[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
  assign PO   = reg_bits[MEMORY_DATA_WIDTH-1:0];
  assign SO   = reg_bits[0];
  assign RDY  = rdy_q;
  assign CEN  = cen_q;
  assign D_WE = d_we_q;

  // Next-state and datapath logic.
  // BGN low overrides everything and returns to IDLE. This also aborts an
  // operation in progress. reg_bits keeps whatever it held, so the host can
  // inspect a partial shift.
  // CTRL is only looked at on the start edge. ctrl_q then steers the rest of
  // the operation.
  always_comb begin
    state_next = state;
    reg_next   = reg_bits;
    cnt_next   = shift_cnt;
    ctrl_next  = ctrl_q;

    if (!BGN) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!LOAD_N) begin
            ctrl_next = CTRL;
            cnt_next  = '0;
            case (CTRL)
              CTRL_LOAD:  state_next = ARM;
              CTRL_READ:  state_next = SRAM_ACC;
              CTRL_WRITE: state_next = SRAM_ACC;
              CTRL_SHOUT: begin
`ifdef SRAM_IO_CTRL_SHIFTOUT_EN
                state_next = ARM;
`else
                state_next = DONE;
`endif
              end
              default:    state_next = IDLE;
            endcase
          end
        end

        // One dead cycle after the strobe. This lets the host put the first
        // serial bit on SI before shifting begins.
        ARM: begin
          cnt_next   = '0;
          state_next = SHIFT;
        end

        // One bit per cycle, for exactly one full register length.
        SHIFT: begin
`ifdef SRAM_IO_CTRL_SHIFTOUT_EN
          if (ctrl_q == CTRL_SHOUT) begin
            reg_next = {reg_bits[0], reg_bits[REG_BITS_WIDTH-1:1]};
          end else begin
            reg_next = {SI, reg_bits[REG_BITS_WIDTH-1:1]};
          end
`else
          reg_next = {SI, reg_bits[REG_BITS_WIDTH-1:1]};
`endif
          cnt_next = shift_cnt + 1'b1;
          if (shift_cnt == LAST_SHIFT) begin
            state_next = DONE;
          end
        end

        // The macro samples A/PO/WEN on the edge that leaves this state.
        // A write is then complete. A read needs one more edge so that Q
        // can be captured.
        SRAM_ACC: begin
          if (ctrl_q == CTRL_WRITE) begin
            state_next = DONE;
          end else begin
            state_next = SRAM_CAP;
          end
        end

        SRAM_CAP: begin
          reg_next[MEMORY_DATA_WIDTH-1:0] = PI;
          state_next = DONE;
        end

        DONE: state_next = DONE;

        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      reg_bits  <= '0;
      shift_cnt <= '0;
      ctrl_q    <= CTRL_LOAD;
    end else begin
      state     <= state_next;
      reg_bits  <= reg_next;
      shift_cnt <= cnt_next;
      ctrl_q    <= ctrl_next;
    end
  end

  // The handshake and SRAM strobes are decoded from the next state and
  // registered. This keeps them glitch-free at the macro pins. The strobes
  // are therefore only active while the FSM is in SRAM_ACC.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q  <= 1'b0;
      cen_q  <= 1'b1;
      d_we_q <= 1'b1;
    end else begin
      rdy_q  <= (state_next == DONE);
      cen_q  <= (state_next != SRAM_ACC);
      d_we_q <= !((state_next == SRAM_ACC) && (ctrl_next == CTRL_WRITE));
    end
  end

endmodule

// File: tb/tb_sram_serial_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_serial_io_ctrl
//
// Directed bench for sram_serial_io_ctrl. A small behavioural model of the
// synchronous 1024x8 SRAM macro answers the DUT. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge, away from the
// rising edge the DUT uses.
// ---------------------------------------------------------------------------
module tb_sram_serial_io_ctrl;

  logic        clk;
  logic        rst_n;
  logic        bgn;
  logic        si;
  logic        load_n;
  logic [1:0]  ctrl;
  logic [7:0]  pi;
  logic        rdy;
  logic        d_we;
  logic        cen;
  logic        so;
  logic [9:0]  a;
  logic [7:0]  po;

  int test_cnt;
  int fail_cnt;
  int access_cnt;

  logic [7:0] mem [0:1023];

  sram_serial_io_ctrl dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .BGN    (bgn),
    .SI     (si),
    .LOAD_N (load_n),
    .CTRL   (ctrl),
    .PI     (pi),
    .RDY    (rdy),
    .D_WE   (d_we),
    .CEN    (cen),
    .SO     (so),
    .A      (a),
    .PO     (po)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAM: on each enabled edge, write D or register Q.
  // access_cnt lets the bench confirm that nothing touched the macro.
  always @(posedge clk) begin
    if (!cen) begin
      access_cnt <= access_cnt + 1;
      if (!d_we) mem[a] <= po;
      else       pi     <= mem[a];
    end
  end

  // One comparison: count it, and on a mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a start strobe with the given CTRL. Afterwards CTRL is scrambled
  // to show that only the start-edge value matters. Returns on the falling
  // edge after E0.
  task automatic applyStimulus(input logic [1:0] op);
    @(negedge clk);
    bgn    = 1'b1;
    load_n = 1'b0;
    ctrl   = op;
    @(posedge clk);
    @(negedge clk);
    load_n = 1'b1;
    ctrl   = ~op;
  endtask

  // Drop BGN and confirm that RDY clears on the next edge.
  task automatic endOp(input string tag);
    bgn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag, 32'(rdy), 32'd0);
  endtask

  // Shift a full word in, LSB first. Checks that RDY is still low before
  // the 18th shift edge and high after it.
  task automatic loadWord(input logic [17:0] word);
    applyStimulus(2'b00);
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      si = word[i];
      if (i == 17) checkOutput("load_rdy_early", 32'(rdy), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("load_rdy", 32'(rdy), 32'd1);
    checkOutput("load_reg", 32'(dut.reg_bits), 32'(word));
  endtask

  // Write one byte: one cycle of CEN=0/D_WE=0, then done.
  task automatic writeByte(input logic [9:0] addr, input logic [7:0] data);
    loadWord({addr, data});
    endOp("wr_pre_end");
    applyStimulus(2'b11);
    checkOutput("wr_cen", 32'(cen), 32'd0);
    checkOutput("wr_we", 32'(d_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wr_cen_off", 32'(cen), 32'd1);
    checkOutput("wr_we_off", 32'(d_we), 32'd1);
    checkOutput("wr_rdy", 32'(rdy), 32'd1);
    endOp("wr_end");
  endtask

  // Read one byte back into reg_bits[7:0]. The address field is kept.
  task automatic readByte(input logic [9:0] addr, input logic [7:0] exp);
    loadWord({addr, 8'h00});
    endOp("rd_pre_end");
    applyStimulus(2'b01);
    checkOutput("rd_cen", 32'(cen), 32'd0);
    checkOutput("rd_we", 32'(d_we), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rd_cap_cen", 32'(cen), 32'd1);
    checkOutput("rd_cap_rdy", 32'(rdy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rd_rdy", 32'(rdy), 32'd1);
    checkOutput("rd_reg", 32'(dut.reg_bits), 32'({addr, exp}));
    endOp("rd_end");
  endtask

  logic [17:0] model;
  logic [17:0] rot_word;
  logic [4:0]  abort_bits;
  logic [7:0]  img [0:13];
  int          acc_before;

  initial begin
    test_cnt   = 0;
    fail_cnt   = 0;
    access_cnt = 0;
    pi         = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n  = 1'b0;
    bgn    = 1'b0;
    si     = 1'b0;
    load_n = 1'b1;
    ctrl   = 2'b00;

    // Reset values
    #12;
    checkOutput("rst_rdy", 32'(rdy), 32'd0);
    checkOutput("rst_cen", 32'(cen), 32'd1);
    checkOutput("rst_we", 32'(d_we), 32'd1);
    checkOutput("rst_reg", 32'(dut.reg_bits), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain load
    loadWord(18'h020AB);
    checkOutput("load_a", 32'(a), 32'h020);
    checkOutput("load_po", 32'(po), 32'hAB);
    checkOutput("load_so", 32'(so), 32'd1);

    // Handshake: RDY holds while BGN stays high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("hold_rdy", 32'(rdy), 32'd1);
      checkOutput("hold_cen", 32'(cen), 32'd1);
    end
    endOp("hs_drop");

    // BGN low with LOAD_N low: nothing starts, no SRAM access
    acc_before = access_cnt;
    load_n = 1'b0;
    ctrl   = 2'b11;
    repeat (5) @(negedge clk);
    checkOutput("idle_rdy", 32'(rdy), 32'd0);
    checkOutput("idle_cen", 32'(cen), 32'd1);
    checkOutput("idle_acc", 32'(access_cnt), 32'(acc_before));
    load_n = 1'b1;

    // Write then read back
    writeByte(10'h000, 8'hAB);
    checkOutput("wr_mem", 32'(mem[0]), 32'hAB);
    readByte(10'h000, 8'hAB);

    // Program image: 14 bytes at 0x020..0x02D
    for (int i = 0; i < 14; i++) img[i] = 8'((i * 37) ^ 8'h5A);
    for (int i = 0; i < 14; i++) writeByte(10'(10'h020 + i), img[i]);
    for (int i = 0; i < 14; i++) readByte(10'(10'h020 + i), img[i]);

    // Abort mid-shift: partial contents stay, strobes idle
    loadWord(18'h2AAAA);
    endOp("ab_pre_end");
    model      = 18'h2AAAA;
    abort_bits = 5'b11001;
    applyStimulus(2'b00);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      si    = abort_bits[i];
      model = {abort_bits[i], model[17:1]};
      @(posedge clk);
    end
    @(negedge clk);
    bgn = 1'b0;
    si  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ab_rdy", 32'(rdy), 32'd0);
    checkOutput("ab_cen", 32'(cen), 32'd1);
    checkOutput("ab_we", 32'(d_we), 32'd1);
    checkOutput("ab_reg", 32'(dut.reg_bits), 32'(model));
    repeat (2) @(negedge clk);
    checkOutput("ab_reg_hold", 32'(dut.reg_bits), 32'(model));

    // Mode 10
    rot_word = 18'h0213C;
    loadWord(rot_word);
    endOp("so_pre_end");
    applyStimulus(2'b10);
`ifdef SRAM_IO_CTRL_SHIFTOUT_EN
    checkOutput("so_arm_rdy", 32'(rdy), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      checkOutput("so_bit", 32'(so), 32'(rot_word[i]));
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("so_rdy", 32'(rdy), 32'd1);
    checkOutput("so_reg", 32'(dut.reg_bits), 32'(rot_word));
`else
    checkOutput("so_nop_rdy", 32'(rdy), 32'd1);
    checkOutput("so_nop_cen", 32'(cen), 32'd1);
    checkOutput("so_nop_reg", 32'(dut.reg_bits), 32'(rot_word));
`endif
    endOp("so_end");

    // Async reset in the middle of a shift
    applyStimulus(2'b00);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      si = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_rdy", 32'(rdy), 32'd0);
    checkOutput("mrst_cen", 32'(cen), 32'd1);
    checkOutput("mrst_we", 32'(d_we), 32'd1);
    checkOutput("mrst_reg", 32'(dut.reg_bits), 32'd0);
    bgn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_rdy", 32'(rdy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
